// File: rtl/dpram_be_pkg.sv
// dpram_be_pkg
//   Shared definitions for the byte-enable dual-port RAM:
//   - read-during-write mode constants (RDW_READ_FIRST / RDW_WRITE_FIRST)
//   - clear/ready state encoding
//   - NB / AW derivation helpers used by the top and the port slices
package dpram_be_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Number of byte-enable lanes in a word.
  function automatic int calc_nb(input int width, input int byte_w);
    return width / byte_w;
  endfunction

  // Word address width; a DEPTH of 2 still needs one address bit.
  function automatic int calc_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dpram_be_port.sv
// dpram_be_port
//   One requester slice of dpram_be: byte-lane merge of the write data into
//   the stored word, read-during-write selection, and the read output
//   pipeline with its valid tag (one or two register stages).
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears outputs)
//   i_req         request accepted this cycle (already gated by READY)
//   i_we          byte-lane write enables
//   i_inr         address is inside the array
//   i_old         stored word at the request address (before this cycle)
//   i_din         write data
//   o_dout        read data, holds when no new result
//   o_valid       o_dout carries a new result this cycle
module dpram_be_port
  import dpram_be_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int BYTE     = 8,
  parameter int RDW_MODE = RDW_READ_FIRST,
  parameter int OUT_REG  = 0,
  localparam int NB      = calc_nb(WIDTH, BYTE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [NB-1:0]    i_we,
  input  logic             i_inr,
  input  logic [WIDTH-1:0] i_old,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid
);

  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_rd;

  always_comb begin
    w_merged = i_old;
    for (int i = 0; i < NB; i++) begin
      if (i_we[i]) w_merged[i*BYTE +: BYTE] = i_din[i*BYTE +: BYTE];
    end
  end

  // Out-of-range requests read as zero whatever the mode.
  always_comb begin
    w_rd = '0;
    if (i_inr) w_rd = (RDW_MODE == RDW_WRITE_FIRST) ? w_merged : i_old;
  end

  // ---- stage p0: read result register ----
  logic [WIDTH-1:0] r_dout_p0;
  logic             r_vld_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_p0 <= '0;
      r_vld_p0  <= 1'b0;
    end else begin
      r_vld_p0 <= i_req;
      if (i_req) r_dout_p0 <= w_rd;
    end
  end

  // ---- stage p1: optional output register ----
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] r_dout_p1;
      logic             r_vld_p1;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout_p1 <= '0;
          r_vld_p1  <= 1'b0;
        end else begin
          r_vld_p1 <= r_vld_p0;
          if (r_vld_p0) r_dout_p1 <= r_dout_p0;
        end
      end

      assign o_dout  = r_dout_p1;
      assign o_valid = r_vld_p1;
    end else begin : g_no_out_reg
      assign o_dout  = r_dout_p0;
      assign o_valid = r_vld_p0;
    end
  endgenerate

endmodule

// File: rtl/dpram_be.sv
// dpram_be
//   Single-clock true dual-port RAM with per-byte write enables. After every
//   reset the array is cleared one word per cycle; init_busy stays high until
//   the clear completes and requests are ignored meanwhile.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ena/wea/addra/dina             port A request (wea==0 means read)
//   douta/valida                   port A read result and its valid pulse
//   enb/web/addrb/dinb/doutb/validb  port B, same as port A
//   init_busy                      high during reset and memory clear
//   collision                      one-cycle pulse after a same-address
//                                  write/write conflict
module dpram_be
  import dpram_be_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int BYTE     = 8,
  parameter int RDW_MODE = RDW_READ_FIRST,
  parameter int OUT_REG  = 0,
  localparam int NB      = calc_nb(WIDTH, BYTE),
  localparam int AW      = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [NB-1:0]    wea,
  input  logic [AW-1:0]    addra,
  input  logic [WIDTH-1:0] dina,
  output logic [WIDTH-1:0] douta,
  output logic             valida,
  input  logic             enb,
  input  logic [NB-1:0]    web,
  input  logic [AW-1:0]    addrb,
  input  logic [WIDTH-1:0] dinb,
  output logic [WIDTH-1:0] doutb,
  output logic             validb,
  output logic             init_busy,
  output logic             collision
);

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  state_e           r_state;
  logic [AW-1:0]    r_clr_addr;
  logic             r_init_busy;
  logic             r_collision;

  logic             w_ready;
  logic             w_acc_a, w_acc_b;
  logic             w_inr_a, w_inr_b;
  logic             w_wr_a, w_wr_b;
  logic [WIDTH-1:0] w_old_a, w_old_b;

  // A request arriving together with rst is dropped: rst wins over READY.
  assign w_ready = (r_state == ST_READY) && !rst;
  assign w_acc_a = w_ready && ena;
  assign w_acc_b = w_ready && enb;
  assign w_inr_a = {1'b0, addra} < DEPTH_L;
  assign w_inr_b = {1'b0, addrb} < DEPTH_L;
  assign w_wr_a  = w_acc_a && w_inr_a;
  assign w_wr_b  = w_acc_b && w_inr_b;
  assign w_old_a = w_inr_a ? r_mem[addra] : '0;
  assign w_old_b = w_inr_b ? r_mem[addrb] : '0;

  // Clear sequencer: walk 0..DEPTH-1, leave for READY once the last word is
  // written with rst low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_CLEAR;
      r_clr_addr  <= '0;
      r_init_busy <= 1'b1;
    end else if (r_state == ST_CLEAR) begin
      if (r_clr_addr == LAST) begin
        r_state     <= ST_READY;
        r_init_busy <= 1'b0;
      end else begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
    end
  end

  // Array write. Port B lanes are applied first and port A lanes last, so on
  // a same-address conflict A owns every lane it enables and B keeps only
  // the lanes A leaves alone.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (w_wr_b && web[i]) r_mem[addrb][i*BYTE +: BYTE] <= dinb[i*BYTE +: BYTE];
      end
      for (int i = 0; i < NB; i++) begin
        if (w_wr_a && wea[i]) r_mem[addra][i*BYTE +: BYTE] <= dina[i*BYTE +: BYTE];
      end
    end
  end

  // Collision flag is registered straight from the request, so it keeps a
  // one-cycle latency independent of the read pipeline depth.
  always_ff @(posedge clk) begin
    if (rst) r_collision <= 1'b0;
    else     r_collision <= w_acc_a && w_acc_b && w_inr_a && (addra == addrb)
                            && (|wea) && (|web);
  end

  assign init_busy = r_init_busy;
  assign collision = r_collision;

  dpram_be_port #(
    .WIDTH(WIDTH), .BYTE(BYTE), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)
  ) u_port_a (
    .clk(clk), .rst(rst), .i_req(w_acc_a), .i_we(wea), .i_inr(w_inr_a),
    .i_old(w_old_a), .i_din(dina), .o_dout(douta), .o_valid(valida)
  );

  dpram_be_port #(
    .WIDTH(WIDTH), .BYTE(BYTE), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)
  ) u_port_b (
    .clk(clk), .rst(rst), .i_req(w_acc_b), .i_we(web), .i_inr(w_inr_b),
    .i_old(w_old_b), .i_din(dinb), .o_dout(doutb), .o_valid(validb)
  );

endmodule
